// File: rtl/i2c_data_phase.sv
// ---------------------------------------------------------------------------
// i2c_data_phase
//
// Purpose: moves one 9-bit I2C frame (8 data bits MSB first, then an ACK
// bit) on a bit-banged SCL/SDA pair. Each bit has four phases:
//   DATA0: SCL low,  SDA set up
//   DATA1: SCL high (rising edge)
//   DATA2: SCL high, SDA sampled at the end of the phase
//   DATA3: SCL low  (falling edge), then move on to the next bit
// Each phase lasts (div_reg + 1) clk cycles. Between frames SCL is held low
// and SDA is released.
//
// Optional feature: define I2C_CLOCK_STRETCH_EN to add the scl input. With it,
// a slave that holds SCL low stalls the DATA1 phase until SCL is seen high.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   scl           in   synchronised SCL level (only with I2C_CLOCK_STRETCH_EN)
//   start         in   request one frame (sampled only in IDLE)
//   clock_divisor in   [15:0] quarter-bit length minus one, in clk cycles
//   tx_data       in   [7:0] byte to send, MSB first
//   tx_ack        in   ninth bit to drive (1 = release SDA)
//   sda           in   synchronised SDA level
//   sda_out       out  SDA drive (1 = released)
//   scl_out       out  SCL drive (1 = released)
//   data_phase    out  high in any DATA state
//   busy          out  high whenever not IDLE
//   done          out  one-cycle pulse in the first IDLE cycle after a frame
//   rx_data       out  [7:0] sampled bits 8..1
//   rx_ack        out  sampled ninth bit
// ---------------------------------------------------------------------------
module i2c_data_phase (
  input  logic        clk,
  input  logic        reset,
`ifdef I2C_CLOCK_STRETCH_EN
  input  logic        scl,
`endif
  input  logic        start,
  input  logic [15:0] clock_divisor,
  input  logic [7:0]  tx_data,
  input  logic        tx_ack,
  input  logic        sda,
  output logic        sda_out,
  output logic        scl_out,
  output logic        data_phase,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rx_data,
  output logic        rx_ack
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA0 = 3'd1,
    DATA1 = 3'd2,
    DATA2 = 3'd3,
    DATA3 = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ctr_q, ctr_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  tx_q, tx_d;
  logic [8:0]  rx_q, rx_d;
  logic        done_q, done_d;
  logic        stall;

  // A slave stretching the clock keeps SCL low after we release it; hold the
  // high-phase counter at zero until the line actually rises.
`ifdef I2C_CLOCK_STRETCH_EN
  assign stall = (state_q == DATA1) && !scl;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ctr_q     <= 16'd0;
      div_q     <= 16'd0;
      bit_cnt_q <= 4'd0;
      tx_q      <= 9'h1FF;
      rx_q      <= 9'h1FF;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    done_d    = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        tx_d      = {tx_data, tx_ack};
        rx_d      = 9'h1FF;
        ctr_d     = 16'd0;
        bit_cnt_d = 4'd0;
        div_d     = clock_divisor;
        state_d   = DATA0;
      end
    end else if (stall) begin
      ctr_d = 16'd0;
    end else if (ctr_q != div_q) begin
      // ctr never exceeds div_q, so it cannot wrap even at 16'hFFFF.
      ctr_d = ctr_q + 16'd1;
    end else begin
      ctr_d = 16'd0;
      case (state_q)
        DATA0: state_d = DATA1;
        DATA1: state_d = DATA2;
        DATA2: begin
          state_d = DATA3;
          rx_d    = {rx_q[7:0], sda};
        end
        DATA3: begin
          tx_d      = {tx_q[7:0], 1'b1};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DATA0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    data_phase = (state_q != IDLE);
    scl_out    = (state_q == DATA1) || (state_q == DATA2);
    sda_out    = (state_q == IDLE) ? 1'b1 : tx_q[8];
  end

  assign done    = done_q;
  assign rx_data = rx_q[8:1];
  assign rx_ack  = rx_q[0];

endmodule

// File: tb/tb_i2c_data_phase.sv
module tb_i2c_data_phase;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] clock_divisor = 16'd0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ack = 1'b1;
  logic        sda;
  logic        sda_out, scl_out, data_phase, busy, done, rx_ack;
  logic [7:0]  rx_data;
  logic        echo_en = 1'b1;
  logic        sda_drv = 1'b1;
`ifdef I2C_CLOCK_STRETCH_EN
  logic        scl_drv = 1'b1;
`endif

  assign sda = echo_en ? sda_out : sda_drv;

  always #5 clk = ~clk;

  i2c_data_phase dut (
    .clk           (clk),
    .reset         (reset),
`ifdef I2C_CLOCK_STRETCH_EN
    .scl           (scl_drv),
`endif
    .start         (start),
    .clock_divisor (clock_divisor),
    .tx_data       (tx_data),
    .tx_ack        (tx_ack),
    .sda           (sda),
    .sda_out       (sda_out),
    .scl_out       (scl_out),
    .data_phase    (data_phase),
    .busy          (busy),
    .done          (done),
    .rx_data       (rx_data),
    .rx_ack        (rx_ack)
  );

  typedef struct {
    logic [7:0] rx;
    logic       ack;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic busy_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: timestamps frame start, pops and compares on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_prev) start_cyc = cyc;
    busy_prev = busy;
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rx_data", int'(rx_data), int'(e.rx));
        chk("rx_ack", int'(rx_ack), int'(e.ack));
        chk("latency", cyc - start_cyc, e.lat);
      end
    end
  end

  // Drive one start pulse; returns at the negedge of the first DATA0 cycle.
  task automatic start_frame(input logic [15:0] div, input logic [7:0] d,
                             input logic a);
    @(negedge clk);
    clock_divisor = div;
    tx_data = d;
    tx_ack = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] rx, input logic ack, input int lat);
    exp_t e;
    e.rx = rx;
    e.ack = ack;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data_phase", int'(data_phase), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sda_out", int'(sda_out), 1);
    chk("rst_scl_out", int'(scl_out), 0);
    chk("rst_rx_data", int'(rx_data), 8'hFF);
    chk("rst_rx_ack", int'(rx_ack), 1);
    reset = 1'b0;
    @(negedge clk);

    // Frame 1: div=3, A5, ack released, SDA echoes -> 144 cycles
    echo_en = 1'b1;
    push_exp(8'hA5, 1'b1, 144);
    start_frame(16'd3, 8'hA5, 1'b1);
    for (int k = 0; k < 32; k++) begin
      if (k != 0) @(negedge clk);
      if (k % 4 == 0) begin
        chk($sformatf("f1_scl_c%0d", k), int'(scl_out),
            ((k / 4) % 4 == 1 || (k / 4) % 4 == 2) ? 1 : 0);
        chk($sformatf("f1_sda_c%0d", k), int'(sda_out), (k < 16) ? 1 : 0);
      end
    end
    wait_idle(400);
    repeat (5) @(negedge clk);
    chk("f1_rx_hold", int'(rx_data), 8'hA5);
    chk("idle_scl_low", int'(scl_out), 0);
    chk("idle_sda_rel", int'(sda_out), 1);

    // Frame 2: div=0, data 00, SDA held low -> 36 cycles
    echo_en = 1'b0;
    sda_drv = 1'b0;
    push_exp(8'h00, 1'b0, 36);
    start_frame(16'd0, 8'h00, 1'b0);
    wait_idle(100);

    // Frame 3: div=1, SDA low only in the ninth DATA2 (cycles 68..69)
    sda_drv = 1'b1;
    push_exp(8'hFF, 1'b0, 72);
    start_frame(16'd1, 8'h3C, 1'b1);
    repeat (68) @(negedge clk);
    sda_drv = 1'b0;
    repeat (2) @(negedge clk);
    sda_drv = 1'b1;
    wait_idle(200);

    // Frame 4: reset during bit 4 DATA2 (div=1 -> cycle 36), no done
    echo_en = 1'b1;
    start_frame(16'd1, 8'hC3, 1'b1);
    repeat (36) @(negedge clk);
    chk("pre_abort_scl", int'(scl_out), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sda_out", int'(sda_out), 1);
    chk("abort_scl_out", int'(scl_out), 0);
    chk("abort_done", int'(done), 0);
    reset = 1'b0;
    repeat (100) @(negedge clk);

    // Frame 5: start pulse and divisor/data changes mid-frame are ignored
    push_exp(8'h5A, 1'b0, 108);
    start_frame(16'd2, 8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    clock_divisor = 16'd7;
    tx_data = 8'hFF;
    tx_ack = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(300);

`ifdef I2C_CLOCK_STRETCH_EN
    // Frame 6: div=2, SCL held low for 10 cycles in bit 0 DATA1 -> 118
    push_exp(8'h96, 1'b1, 118);
    start_frame(16'd2, 8'h96, 1'b1);
    repeat (3) @(negedge clk);
    scl_drv = 1'b0;
    repeat (10) @(negedge clk);
    scl_drv = 1'b1;
    wait_idle(300);
`endif

    repeat (5) @(negedge clk);
    chk("pending_expect", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
